// File: rtl/mem_arbiter_if.sv
// Gameboy-style bus master port: address, data both ways, active-low strobes
// and a one-cycle completion pulse back to the master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] Do;
    logic [DATA_W-1:0] Di;
    logic              wr_n;
    logic              rd_n;
    logic              cs_n;
    logic              ready;

    modport master (output A, Do, wr_n, rd_n, cs_n, input Di, ready);
    modport slave  (input A, Do, wr_n, rd_n, cs_n, output Di, ready);
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the CPU and video buses: one access in
// flight, video first, CPU forced through after STARVE_LIMIT video wins.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_arbiter_if.slave      cpu,
    mem_arbiter_if.slave      vid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              busy,
    output logic              grant_vid
);
    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

    localparam int LAT_INIT = (MEM_LATENCY >= 2) ? MEM_LATENCY - 2 : 0;

    state_t            state_q;
    logic [3:0]        lat_q, streak_q;
    logic              served_cpu_q, served_vid_q;
    logic              owner_vid_q, is_wr_q, busy_q;
    logic              mem_re_q, mem_we_q;
    logic              ready_cpu_q, ready_vid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, cpu_di_q, vid_di_q;

    logic cpu_pend, vid_pend, grant_v, grant_c, done_now, capture;

    always_comb begin
        cpu_pend = ~cpu.cs_n & (cpu.rd_n ^ cpu.wr_n) & ~served_cpu_q;
        vid_pend = ~vid.cs_n & (vid.rd_n ^ vid.wr_n) & ~served_vid_q;
        grant_v  = (state_q == IDLE) & vid_pend &
                   (~cpu_pend | (streak_q != 4'(STARVE_LIMIT)));
        grant_c  = (state_q == IDLE) & cpu_pend & ~grant_v;
        // Last cycle of the access: writes and 1-cycle reads finish in STROBE.
        done_now = ((state_q == STROBE) & (is_wr_q | (MEM_LATENCY == 1))) |
                   ((state_q == WAIT) & (lat_q == 4'd0));
        capture  = done_now & ~is_wr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            streak_q     <= '0;
            served_cpu_q <= 1'b0;
            served_vid_q <= 1'b0;
            owner_vid_q  <= 1'b0;
            is_wr_q      <= 1'b0;
            busy_q       <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            ready_cpu_q  <= 1'b0;
            ready_vid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            ready_cpu_q <= 1'b0;
            ready_vid_q <= 1'b0;
            if (cpu.cs_n) served_cpu_q <= 1'b0;
            if (vid.cs_n) served_vid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!cpu_pend || grant_c)
                        streak_q <= '0;
                    else if (grant_v && streak_q != 4'(STARVE_LIMIT))
                        streak_q <= streak_q + 4'd1;
                    if (grant_v || grant_c) begin
                        state_q     <= STROBE;
                        busy_q      <= 1'b1;
                        owner_vid_q <= grant_v;
                        is_wr_q     <= grant_v ? ~vid.wr_n : ~cpu.wr_n;
                        mem_re_q    <= grant_v ? ~vid.rd_n : ~cpu.rd_n;
                        mem_we_q    <= grant_v ? ~vid.wr_n : ~cpu.wr_n;
                        mem_addr_q  <= grant_v ? vid.A : cpu.A;
                        if (grant_v ? ~vid.wr_n : ~cpu.wr_n)
                            mem_wdata_q <= grant_v ? vid.Do : cpu.Do;
                    end
                end
                STROBE: begin
                    state_q <= done_now ? DONE : WAIT;
                    lat_q   <= 4'(LAT_INIT);
                end
                WAIT: begin
                    if (done_now) state_q <= DONE;
                    else          lat_q   <= lat_q - 4'd1;
                end
                DONE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    owner_vid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            // Served is set with the ready pulse so a held cs_n cannot re-trigger.
            if (done_now) begin
                if (owner_vid_q) begin
                    ready_vid_q  <= 1'b1;
                    served_vid_q <= 1'b1;
                end else begin
                    ready_cpu_q  <= 1'b1;
                    served_cpu_q <= 1'b1;
                end
            end
        end
    end

    // Read data is kept across reset so an aborted read leaves Di untouched.
    always_ff @(posedge clock) begin
        if (!reset && capture) begin
            if (owner_vid_q) vid_di_q <= mem_rdata;
            else             cpu_di_q <= mem_rdata;
        end
    end

    assign cpu.Di    = cpu_di_q;
    assign vid.Di    = vid_di_q;
    assign cpu.ready = ready_cpu_q;
    assign vid.ready = ready_vid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = busy_q;
    assign grant_vid = owner_vid_q;
endmodule
